// File: rtl/regfile_np.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_np : one-write / NRD-read register file with optional bypass,     |
// |              registered reads and hardwired-zero register 0.              |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module regfile_np #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_OUT  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic [NRD-1:0]       re,
  input  logic [NRD*AW-1:0]    raddr,
  output logic [NRD*WIDTH-1:0] rdata,
  output logic [NRD-1:0]       rvalid
);

  // Registered reads always see post-write storage, so they forward regardless of BYPASS.
  localparam bit c_FWD  = (BYPASS != 0) || (REG_OUT != 0);
  localparam bit c_ZERO = (ZERO_REG != 0);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_en;

  assign w_wr_en = we && !(c_ZERO && (waddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_val;

    assign w_addr = raddr[k*AW +: AW];

    always_comb begin
      w_val = r_mem[w_addr];
      if (c_ZERO && (w_addr == '0)) begin
        w_val = '0;
      end else if (c_FWD && we && (w_addr == waddr)) begin
        w_val = wdata;
      end
    end

    if (REG_OUT != 0) begin : g_reg
      logic [WIDTH-1:0] r_data;
      logic             r_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_data <= re[k] ? w_val : '0;
          r_vld  <= re[k];
        end
      end

      assign rdata[k*WIDTH +: WIDTH] = r_data;
      assign rvalid[k]               = r_vld;
    end else begin : g_comb
      // Outputs are forced low while reset is held, even though the path is combinational.
      assign rdata[k*WIDTH +: WIDTH] = (re[k] && rst_n) ? w_val : '0;
      assign rvalid[k]               = re[k] && rst_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_np.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_np : directed self-checking bench over three configurations.   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_regfile_np;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [4:0]   waddr;
  logic [31:0]  wdata;
  logic [1:0]   re_a;
  logic [9:0]   raddr_a;
  logic [63:0]  rdata_a, rdata_b;
  logic [1:0]   rvalid_a, rvalid_b;
  logic [3:0]   re_c;
  logic [19:0]  raddr_c;
  logic [127:0] rdata_c;
  logic [3:0]   rvalid_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // A: zero reg + bypass, combinational read
  regfile_np #(.NRD(2), .ZERO_REG(1), .BYPASS(1), .REG_OUT(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re_a), .raddr(raddr_a), .rdata(rdata_a), .rvalid(rvalid_a)
  );

  // B: no zero reg, no bypass, combinational read
  regfile_np #(.NRD(2), .ZERO_REG(0), .BYPASS(0), .REG_OUT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re_a), .raddr(raddr_a), .rdata(rdata_b), .rvalid(rvalid_b)
  );

  // C: four registered read ports, no bypass flag (forwarding is implicit)
  regfile_np #(.NRD(4), .ZERO_REG(1), .BYPASS(0), .REG_OUT(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re_c), .raddr(raddr_c), .rdata(rdata_c), .rvalid(rvalid_c)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk); #1;
    we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    re_a    = 2'b11;
    raddr_a = {5'd31, 5'd3};
    re_c    = 4'b1111;
    raddr_c = '0;
    #3;
    check("rst_rdata_a",  rdata_a,  0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rdata_c",  rdata_c,  0);
    check("rst_rvalid_c", rvalid_c, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 1; i < 32; i++) wr(i[4:0], 32'hA5A5_0000 + i);
    #1;
    check("load_rdata_a",  rdata_a,  {32'hA5A5_001F, 32'hA5A5_0003});
    check("load_rvalid_a", rvalid_a, 2'b11);
    check("load_rdata_b",  rdata_b,  {32'hA5A5_001F, 32'hA5A5_0003});

    // asynchronous reset pulse mid-cycle
    #1 rst_n = 1'b0;
    #1;
    check("arst_rdata_a",  rdata_a,  0);
    check("arst_rvalid_a", rvalid_a, 0);
    check("arst_rdata_c",  rdata_c,  0);
    check("arst_rvalid_c", rvalid_c, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_rdata_a",  rdata_a,  0);
    check("post_rst_rvalid_a", rvalid_a, 2'b11);
    check("post_rst_rdata_b",  rdata_b,  0);

    // zero register with bypass active
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF; raddr_a = {5'd0, 5'd0}; re_a = 2'b11;
    #1;
    check("zero_byp_a", rdata_a, 0);
    check("zero_old_b", rdata_b, 0);
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("zero_after_a", rdata_a, 0);
    check("zero_after_b", rdata_b, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

    // bypass versus no-bypass on a same-cycle write/read
    wr(5'd6, 32'h66);
    we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr_a = {5'd6, 5'd5};
    #1;
    check("byp_a",   rdata_a, {32'h66, 32'h1234_5678});
    check("nobyp_b", rdata_b, {32'h66, 32'h0});
    @(posedge clk); #1;
    we = 1'b0;
    #1;
    check("nobyp_after_b", rdata_b, {32'h66, 32'h1234_5678});

    // registered read ports with a partial enable mask
    wr(5'd1, 32'h11);
    wr(5'd2, 32'h22);
    wr(5'd3, 32'h33);
    wr(5'd4, 32'h44);
    raddr_c = {5'd4, 5'd3, 5'd2, 5'd1};
    re_c    = 4'b1011;
    @(posedge clk); #1;
    check("reg_rdata_c",  rdata_c,  {32'h44, 32'h0, 32'h22, 32'h11});
    check("reg_rvalid_c", rvalid_c, 4'b1011);
    raddr_c = '0;
    re_c    = 4'b0000;
    #2;
    check("hold_rdata_c",  rdata_c,  {32'h44, 32'h0, 32'h22, 32'h11});
    check("hold_rvalid_c", rvalid_c, 4'b1011);

    // registered mode forwards the write on the same edge; port 1 reads the zero register
    we = 1'b1; waddr = 5'd2; wdata = 32'hBB;
    raddr_c = {5'd0, 5'd0, 5'd0, 5'd2};
    re_c    = 4'b0011;
    @(posedge clk); #1;
    we = 1'b0;
    check("fwd_rdata_c",  rdata_c,  {32'h0, 32'h0, 32'h0, 32'hBB});
    check("fwd_rvalid_c", rvalid_c, 4'b0011);

    // read-enable gating
    wr(5'd7, 32'h77);
    re_a = 2'b10; raddr_a = {5'd2, 5'd7};
    #1;
    check("gate_off_rdata_a",  rdata_a,  {32'hBB, 32'h0});
    check("gate_off_rvalid_a", rvalid_a, 2'b10);
    re_a = 2'b11;
    #1;
    check("gate_on_rdata_a",  rdata_a,  {32'hBB, 32'h77});
    check("gate_on_rvalid_a", rvalid_a, 2'b11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_np.md
# regfile_np

Parametrised multi-read-port register file: the storage successor to the fixed 32×32 write-decoder/read-selector pair used in the CPU datapath. It provides one write port and NRD read ports with per-port read enables, optional write-to-read bypass, optional registered read outputs and an optional hardwired-zero register 0. It sits between the instruction decoder and the ALU operand muxes.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers; must be a power of two ≥ 2.
- AW, $clog2(DEPTH): address width (derived; not overridden).
- NRD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = a read of the address being written returns the write data.
- REG_OUT, 0: 0 = combinational read; 1 = registered read, 1-cycle latency.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- re  in  NRD  per-port read enable; bit k controls port k.
- raddr  in  NRD*AW  packed read addresses; port k = raddr[k*AW +: AW].
- rdata  out  NRD*WIDTH  packed read data; port k = rdata[k*WIDTH +: WIDTH].
- rvalid  out  NRD  per-port data-valid flag.

## Operation
- Reset (rst_n low, any time, independent of clk): every storage entry, every rdata bit and every rvalid bit cleared to 0 immediately; held while rst_n low. A write or read in progress at reset assertion is discarded.
- Write: on rising clk with we=1 and rst_n=1, entry[waddr] ← wdata. If ZERO_REG=1 and waddr=0, no storage change.
- Read value for port k, v_k:
  - ZERO_REG=1 and raddr_k=0 → 0 (overrides bypass).
  - else BYPASS=1, we=1, raddr_k=waddr → wdata.
  - else entry[raddr_k].
- Disabled port (re[k]=0): rdata_k = 0, rvalid[k]=0 (matches the disabled-selector convention of driving zero, never Z).
- REG_OUT=0: rdata_k = re[k] ? v_k : 0 combinationally; rvalid[k] = re[k].
- REG_OUT=1: on each rising clk, rdata_k ← re[k] ? v_k : 0 and rvalid[k] ← re[k]; outputs otherwise hold. Bypass in this mode forwards the write occurring on the same edge, so the registered value always equals post-write storage.
- BYPASS=0, REG_OUT=0: same-cycle read of waddr returns old contents; new value visible the cycle after the write edge.
- Multiple ports may address the same entry; each receives the identical value.
- Addresses are always in range (DEPTH is a power of two); no error condition.

## Timing
- Write latency: 1 edge; storage updated at the rising clk where we=1.
- REG_OUT=0: read path purely combinational from raddr/re/we/waddr/wdata to rdata; 0 cycles.
- REG_OUT=1: rdata/rvalid reflect inputs sampled at edge N, visible after edge N; no combinational path from inputs to outputs.
- Simultaneous write and read of same address at edge N:
  - REG_OUT=1, any BYPASS: rdata after edge N = wdata.
  - REG_OUT=0, BYPASS=1: rdata = wdata during cycle before edge N.
  - REG_OUT=0, BYPASS=0: rdata = old value before edge N, new after.
- Reset release: first write or registered read occurs at the first rising clk with rst_n high; no additional wait cycles.
- Throughput: one write and NRD reads per cycle, sustained, no stalls, no handshake back-pressure.

## Test plan
- Reset: load entries 1..31 with 0xA5A5_0000+i, pulse rst_n low mid-cycle → rdata, rvalid and all entries read 0 immediately, before next clk edge.
- Zero register (ZERO_REG=1): write 0xDEAD_BEEF to addr 0, read addr 0 on both ports with bypass active → 0x0000_0000; ZERO_REG=0 same stimulus → 0xDEAD_BEEF next cycle.
- Bypass (BYPASS=1, REG_OUT=0): we=1, waddr=5, wdata=0x1234_5678, raddr0=5, raddr1=6 (holding 0x66) in same cycle → rdata0=0x1234_5678, rdata1=0x66 before the edge; BYPASS=0 → rdata0=old value 0x0 until after edge.
- Registered mode (REG_OUT=1, NRD=4): issue raddr 1,2,3,4 with re=4'b1011 at edge N → after edge N ports 0,1,3 carry entries 1,2,4, port 2 = 0, rvalid=4'b1011; outputs hold when inputs change mid-cycle.
- Read enable gating: re=0 on port 0 with raddr0=7 (holding 0x77) → rdata0=0, rvalid[0]=0; raise re → 0x77.
- Random soak (WIDTH=16, DEPTH=8, NRD=3, all 8 parameter-flag combinations): 10 000 random cycles with random rst_n pulses against a scoreboard model → zero mismatches.
